sd_cmd_engine: RTL

//  Host-side SD command-line controller: parametrised successor of the single-shot command FSM.

---
 rtl/sd_cmd_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_engine.sv
// SD host command-line engine: frames a 40-bit command, waits for a none/short/long response,
// checks index, times out and retries. Define CMD_CRC7_CHECK_EN to also check CRC7 on short responses.
module sd_cmd_engine #(
  parameter int TMO_W   = 32,
  parameter int RETRY_W = 2,
  parameter int LRESP_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_command,
  input  logic [5:0]         cmd_index,
  input  logic [31:0]        cmd_argument,
  input  logic [1:0]         resp_type,
  input  logic [TMO_W-1:0]   timeout_reg,
  input  logic [RETRY_W-1:0] max_retries,
  input  logic               serial_ready,
  input  logic               ack_in,
  input  logic               strobe_in,
  input  logic [39:0]        cmd_in,
  input  logic [LRESP_W-1:0] resp_in,
  input  logic [6:0]         crc_in,
  output logic [39:0]        cmd_out,
  output logic               strobe_out,
  output logic               ack_out,
  output logic               idle_out,
  output logic               busy,
  output logic [LRESP_W-1:0] response,
  output logic               command_complete,
  output logic               command_timeout,
  output logic               command_index_error,
  output logic               command_crc_error,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state_dbg
);

  // Handshakes: new_command, ack_in, strobe_in, strobe_out, ack_out and command_complete are
  // single-cycle pulses sampled on the rising clock; serial_ready is a level that gates the frame
  // strobe. Each input pulse is acted on only in the state that waits for it, otherwise dropped.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [1:0]         rtype_q, rtype_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n;
  logic [RETRY_W-1:0] retry_n;
  logic [39:0]        cmd_out_n;
  logic [LRESP_W-1:0] resp_n;
  logic               strobe_n, ack_n, complete_n;
  logic               tmo_flag_n, idx_flag_n, crc_flag_n;
  logic               err_tmo, err_idx, err_crc;
  logic               crc_bad;

`ifdef CMD_CRC7_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--)
      c = {c[5:0], 1'b0} ^ ((c[6] ^ d[i]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  assign crc_bad = (crc7(cmd_in) != crc_in);
`else
  logic unused_crc;
  assign unused_crc = ^{crc_in, cmd_in[39:38]};
  assign crc_bad    = 1'b0;
`endif

  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    rtype_n    = rtype_q;
    tmo_n      = tmo_cnt;
    retry_n    = retry_count;
    cmd_out_n  = cmd_out;
    resp_n     = response;
    strobe_n   = 1'b0;
    ack_n      = 1'b0;
    complete_n = 1'b0;
    tmo_flag_n = command_timeout;
    idx_flag_n = command_index_error;
    crc_flag_n = command_crc_error;
    err_tmo    = 1'b0;
    err_idx    = 1'b0;
    err_crc    = 1'b0;

    case (state)
      S_IDLE: begin
        if (new_command) begin
          cmd_out_n  = {2'b01, cmd_index, cmd_argument};
          rtype_n    = resp_type;
          retry_n    = '0;
          tmo_n      = '0;
          tmo_flag_n = 1'b0;
          idx_flag_n = 1'b0;
          crc_flag_n = 1'b0;
          state_n    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (serial_ready) begin
          strobe_n = 1'b1;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_in) begin
          if (rtype_q == 2'b00) begin
            state_n = S_DONE;
          end else begin
            tmo_n   = '0;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A strobe in the same cycle as the timeout limit still counts as a response.
        if (strobe_in) begin
          if (rtype_q == 2'b10) begin
            resp_n  = resp_in;
            ack_n   = 1'b1;
            state_n = S_DONE;
          end else if (cmd_in[37:32] != cmd_out[37:32]) begin
            err_idx = 1'b1;
          end else if (crc_bad) begin
            err_crc = 1'b1;
          end else begin
            resp_n  = LRESP_W'(cmd_in[31:0]);
            ack_n   = 1'b1;
            state_n = S_DONE;
          end
        end else if (tmo_cnt >= timeout_reg) begin
          err_tmo = 1'b1;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      S_DONE: begin
        complete_n = 1'b1;
        state_n    = S_IDLE;
      end
      S_ERR: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Retries resend the latched frame; only the final failure raises a sticky flag.
    if (err_tmo || err_idx || err_crc) begin
      if (retry_count < max_retries) begin
        retry_n = retry_count + RETRY_W'(1);
        state_n = S_LOAD;
      end else begin
        tmo_flag_n = command_timeout     | err_tmo;
        idx_flag_n = command_index_error | err_idx;
        crc_flag_n = command_crc_error   | err_crc;
        state_n    = S_ERR;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      rtype_q             <= 2'b00;
      tmo_cnt             <= '0;
      retry_count         <= '0;
      cmd_out             <= '0;
      response            <= '0;
      strobe_out          <= 1'b0;
      ack_out             <= 1'b0;
      command_complete    <= 1'b0;
      command_timeout     <= 1'b0;
      command_index_error <= 1'b0;
      command_crc_error   <= 1'b0;
      idle_out            <= 1'b1;
      busy                <= 1'b0;
    end else begin
      state               <= state_n;
      rtype_q             <= rtype_n;
      tmo_cnt             <= tmo_n;
      retry_count         <= retry_n;
      cmd_out             <= cmd_out_n;
      response            <= resp_n;
      strobe_out          <= strobe_n;
      ack_out             <= ack_n;
      command_complete    <= complete_n;
      command_timeout     <= tmo_flag_n;
      command_index_error <= idx_flag_n;
      command_crc_error   <= crc_flag_n;
      idle_out            <= (state_n == S_IDLE);
      busy                <= (state_n != S_IDLE);
    end
  end

endmodule
